// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage plus IF/ID pipeline register for the MIPS pipeline.
//
// Holds the PC and drives instruction-memory addressing. It registers the fetched word
// into decode and redirects the PC when the decode-stage control signals (J / BranchEQ /
// BranchNE, qualified by the register compare) mark a taken branch or jump.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   imem_addr    fetch address (the PC register)
//   imem_rdata   instruction word read combinationally from imem_addr
//   stall        hazard-unit stall; freezes PC and IF/ID and suppresses redirect
//   J            jump, from the decode-stage control unit
//   BranchEQ     beq, from the control unit
//   BranchNE     bne, from the control unit
//   zero         decode-stage compare, 1 when rs == rt
//   id_instr     IF/ID instruction register (0 when the slot is a bubble)
//   id_op        id_instr[31:26], feeds the control unit
//   id_pc_plus4  IF/ID copy of fetch PC + 4
//   id_valid     IF/ID slot holds a real instruction
//   redirect     a taken branch/jump is in decode this cycle
//   taken_count  number of taken redirects since reset (wraps)
//
// Build option: define DELAY_SLOT_EN for the architectural delay slot. The word fetched
// alongside a taken redirect then still enters decode. Without it, that word is squashed
// into a bubble.

module fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0040_0000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [31:0]          imem_addr,
    input  logic [31:0]          imem_rdata,
    input  logic                 stall,
    input  logic                 J,
    input  logic                 BranchEQ,
    input  logic                 BranchNE,
    input  logic                 zero,
    output logic [31:0]          id_instr,
    output logic [5:0]           id_op,
    output logic [31:0]          id_pc_plus4,
    output logic                 id_valid,
    output logic                 redirect,
    output logic [CNT_WIDTH-1:0] taken_count
);

    logic [31:0]          pc_q, pc_d;
    logic [31:0]          id_instr_q, id_instr_d;
    logic [31:0]          id_pc_plus4_q, id_pc_plus4_d;
    logic                 id_valid_q, id_valid_d;
    logic [CNT_WIDTH-1:0] taken_count_q, taken_count_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        taken;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = id_pc_plus4_q + {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
    assign jump_target   = {id_pc_plus4_q[31:28], id_instr_q[25:0], 2'b00};

    // Gating on id_valid keeps stale control decode of a bubble from redirecting.
    assign taken = id_valid_q & ~stall & (J | (BranchEQ & zero) | (BranchNE & ~zero));

    always_comb begin
        pc_d          = pc_q;
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_valid_d    = id_valid_q;
        taken_count_d = taken_count_q;
        if (!stall) begin
            if (taken) begin
                pc_d          = J ? jump_target : branch_target;
                taken_count_d = taken_count_q + CNT_WIDTH'(1);
`ifdef DELAY_SLOT_EN
                // Delay slot: the branch+4 word still enters decode.
                id_instr_d    = imem_rdata;
                id_pc_plus4_d = pc_plus4;
                id_valid_d    = 1'b1;
`else
                // Squash the branch+4 word into an sll $0,$0,0 bubble.
                id_instr_d    = 32'h0000_0000;
                id_pc_plus4_d = 32'h0000_0000;
                id_valid_d    = 1'b0;
`endif
            end else begin
                pc_d          = pc_plus4;
                id_instr_d    = imem_rdata;
                id_pc_plus4_d = pc_plus4;
                id_valid_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q          <= PC_RESET;
            id_instr_q    <= 32'h0000_0000;
            id_pc_plus4_q <= 32'h0000_0000;
            id_valid_q    <= 1'b0;
            taken_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_instr    = id_instr_q;
    assign id_op       = id_instr_q[31:26];
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_valid    = id_valid_q;
    assign redirect    = taken;
    assign taken_count = taken_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. The instruction memory holds word k = 32'h2008_0000+k
// at 0x0040_0000 + 4k, with a beq (offset 3) at 0x0040_0010. Control inputs are driven
// directly by the bench in place of the control unit.

module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] BEQ3   = 32'h1000_0003;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        J;
    logic        BranchEQ;
    logic        BranchNE;
    logic        zero;
    logic [31:0] id_instr;
    logic [5:0]  id_op;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic        redirect;
    logic [15:0] taken_count;

    logic [31:0] mem [0:127];
    logic [31:0] widx;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        widx = (imem_addr - RST_PC) >> 2;
        imem_rdata = (widx < 32'd128) ? mem[widx[6:0]] : 32'h0000_0000;
    end

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .J           (J),
        .BranchEQ    (BranchEQ),
        .BranchNE    (BranchNE),
        .zero        (zero),
        .id_instr    (id_instr),
        .id_op       (id_op),
        .id_pc_plus4 (id_pc_plus4),
        .id_valid    (id_valid),
        .redirect    (redirect),
        .taken_count (taken_count)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall = 0; J = 0; BranchEQ = 0; BranchNE = 0; zero = 0;
    endtask

    // Two reset edges, then release; returns in cycle 0 with PC = RST_PC.
    task automatic do_reset();
        reset = 0;
        clear_ctrl();
        tick(2);
        reset = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (imem_addr !== RST_PC) begin n_err++; $display("FAIL reset_pc: got %h expected %h", imem_addr, RST_PC); end
        n_vec++; if (id_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h expected %h", id_instr, 32'h0); end
        n_vec++; if (id_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL reset_pc4: got %h expected %h", id_pc_plus4, 32'h0); end
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
        n_vec++; if (taken_count !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", taken_count); end
        n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL reset_redirect: got %b expected 0", redirect); end
        // Reset wins over stall mid-run.
        tick(3);
        stall = 1; reset = 0;
        tick(1);
        n_vec++; if (imem_addr !== RST_PC) begin n_err++; $display("FAIL reset_over_stall: got %h expected %h", imem_addr, RST_PC); end
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_over_stall_valid: got %b expected 0", id_valid); end
        reset = 1; stall = 0;
    endtask

    task automatic test_seq_fetch();
        do_reset();
        n_vec++; if (imem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL seq_addr0: got %h expected %h", imem_addr, 32'h0040_0000); end
        tick(1);
        n_vec++; if (imem_addr !== 32'h0040_0004) begin n_err++; $display("FAIL seq_addr1: got %h expected %h", imem_addr, 32'h0040_0004); end
        n_vec++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid: got %b expected 1", id_valid); end
        n_vec++; if (id_instr !== 32'h2008_0000) begin n_err++; $display("FAIL seq_instr0: got %h expected %h", id_instr, 32'h2008_0000); end
        n_vec++; if (id_pc_plus4 !== 32'h0040_0004) begin n_err++; $display("FAIL seq_pc4: got %h expected %h", id_pc_plus4, 32'h0040_0004); end
        n_vec++; if (id_op !== 6'h08) begin n_err++; $display("FAIL seq_op: got %h expected %h", id_op, 6'h08); end
        tick(1);
        n_vec++; if (imem_addr !== 32'h0040_0008) begin n_err++; $display("FAIL seq_addr2: got %h expected %h", imem_addr, 32'h0040_0008); end
        n_vec++; if (id_instr !== 32'h2008_0001) begin n_err++; $display("FAIL seq_instr1: got %h expected %h", id_instr, 32'h2008_0001); end
    endtask

    task automatic test_beq_taken();
        do_reset();
        tick(5);
        n_vec++; if (id_instr !== BEQ3) begin n_err++; $display("FAIL beq_in_decode: got %h expected %h", id_instr, BEQ3); end
        BranchEQ = 1; zero = 1;
        #1;
        n_vec++; if (redirect !== 1'b1) begin n_err++; $display("FAIL beq_redirect: got %b expected 1", redirect); end
        tick(1);
        n_vec++; if (imem_addr !== 32'h0040_0020) begin n_err++; $display("FAIL beq_target: got %h expected %h", imem_addr, 32'h0040_0020); end
        n_vec++; if (taken_count !== 16'd1) begin n_err++; $display("FAIL beq_cnt: got %0d expected 1", taken_count); end
`ifdef DELAY_SLOT_EN
        n_vec++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL ds_valid: got %b expected 1", id_valid); end
        n_vec++; if (id_instr !== 32'h2008_0005) begin n_err++; $display("FAIL ds_instr: got %h expected %h", id_instr, 32'h2008_0005); end
        n_vec++; if (id_pc_plus4 !== 32'h0040_0018) begin n_err++; $display("FAIL ds_pc4: got %h expected %h", id_pc_plus4, 32'h0040_0018); end
        BranchEQ = 0; zero = 0;
`else
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL bubble_valid: got %b expected 0", id_valid); end
        n_vec++; if (id_instr !== 32'h0) begin n_err++; $display("FAIL bubble_instr: got %h expected %h", id_instr, 32'h0); end
        n_vec++; if (id_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL bubble_pc4: got %h expected %h", id_pc_plus4, 32'h0); end
        // Control still asserted, but a bubble must not redirect.
        n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL bubble_redirect: got %b expected 0", redirect); end
        BranchEQ = 0; zero = 0;
`endif
        #1;
        n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL beq_redirect_once: got %b expected 0", redirect); end
        tick(1);
        n_vec++; if (id_instr !== 32'h2008_0008) begin n_err++; $display("FAIL beq_target_word: got %h expected %h", id_instr, 32'h2008_0008); end
        n_vec++; if (id_pc_plus4 !== 32'h0040_0024) begin n_err++; $display("FAIL beq_target_pc4: got %h expected %h", id_pc_plus4, 32'h0040_0024); end
    endtask

    task automatic test_bne_not_taken();
        do_reset();
        tick(5);
        BranchNE = 1; zero = 1;
        #1;
        n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL bne_redirect: got %b expected 0", redirect); end
        tick(1);
        n_vec++; if (imem_addr !== 32'h0040_0018) begin n_err++; $display("FAIL bne_pc: got %h expected %h", imem_addr, 32'h0040_0018); end
        n_vec++; if (taken_count !== 16'd0) begin n_err++; $display("FAIL bne_cnt: got %0d expected 0", taken_count); end
        n_vec++; if (id_instr !== 32'h2008_0005) begin n_err++; $display("FAIL bne_instr: got %h expected %h", id_instr, 32'h2008_0005); end
        clear_ctrl();
    endtask

    task automatic test_jump();
        mem[1] = 32'h0810_0040;
        do_reset();
        tick(2);
        n_vec++; if (id_pc_plus4 !== 32'h0040_0008) begin n_err++; $display("FAIL j_pc4: got %h expected %h", id_pc_plus4, 32'h0040_0008); end
        // Branch inputs also asserted: the jump target must still win.
        J = 1; BranchEQ = 1; zero = 1;
        #1;
        n_vec++; if (id_op !== 6'h02) begin n_err++; $display("FAIL j_op: got %h expected %h", id_op, 6'h02); end
        n_vec++; if (redirect !== 1'b1) begin n_err++; $display("FAIL j_redirect: got %b expected 1", redirect); end
        tick(1);
        n_vec++; if (imem_addr !== 32'h0040_0100) begin n_err++; $display("FAIL j_target: got %h expected %h", imem_addr, 32'h0040_0100); end
        n_vec++; if (taken_count !== 16'd1) begin n_err++; $display("FAIL j_cnt: got %0d expected 1", taken_count); end
        clear_ctrl();
        mem[1] = 32'h2008_0001;
    endtask

    task automatic test_stall_branch();
        do_reset();
        tick(5);
        stall = 1; BranchEQ = 1; zero = 1;
        #1;
        n_vec++; if (redirect !== 1'b0) begin n_err++; $display("FAIL stall_redirect: got %b expected 0", redirect); end
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_vec++; if (imem_addr !== 32'h0040_0014) begin n_err++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, imem_addr, 32'h0040_0014); end
            n_vec++; if (id_instr !== BEQ3) begin n_err++; $display("FAIL stall_instr[%0d]: got %h expected %h", i, id_instr, BEQ3); end
            n_vec++; if (taken_count !== 16'd0) begin n_err++; $display("FAIL stall_cnt[%0d]: got %0d expected 0", i, taken_count); end
        end
        stall = 0;
        #1;
        n_vec++; if (redirect !== 1'b1) begin n_err++; $display("FAIL unstall_redirect: got %b expected 1", redirect); end
        tick(1);
        n_vec++; if (imem_addr !== 32'h0040_0020) begin n_err++; $display("FAIL unstall_target: got %h expected %h", imem_addr, 32'h0040_0020); end
        n_vec++; if (taken_count !== 16'd1) begin n_err++; $display("FAIL unstall_cnt: got %0d expected 1", taken_count); end
        clear_ctrl();
    endtask

    // Backward bne (offset -5 from 0x0040_0014 lands on 0x0040_0000), taken twice in a row.
    task automatic test_back_to_back();
        mem[4] = 32'h1400_FFFB;
        do_reset();
        tick(5);
        BranchNE = 1; zero = 0;
        tick(1);
        n_vec++; if (imem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL neg_target: got %h expected %h", imem_addr, 32'h0040_0000); end
        BranchNE = 0;
        tick(5);
        n_vec++; if (id_instr !== 32'h1400_FFFB) begin n_err++; $display("FAIL neg_refetch: got %h expected %h", id_instr, 32'h1400_FFFB); end
        BranchNE = 1;
        tick(1);
        n_vec++; if (taken_count !== 16'd2) begin n_err++; $display("FAIL neg_cnt: got %0d expected 2", taken_count); end
        BranchNE = 0;
        // Reset on a redirect cycle still wins.
        tick(5);
        BranchNE = 1; reset = 0;
        tick(1);
        n_vec++; if (imem_addr !== RST_PC) begin n_err++; $display("FAIL reset_on_redirect_pc: got %h expected %h", imem_addr, RST_PC); end
        n_vec++; if (taken_count !== 16'd0) begin n_err++; $display("FAIL reset_on_redirect_cnt: got %0d expected 0", taken_count); end
        reset = 1;
        clear_ctrl();
        mem[4] = BEQ3;
    endtask

    initial begin
        for (int k = 0; k < 128; k++) mem[k] = 32'h2008_0000 + k;
        mem[4] = BEQ3;
        reset = 0;
        clear_ctrl();
        test_reset();
        test_seq_fetch();
        test_beq_taken();
        test_bne_not_taken();
        test_jump();
        test_stall_branch();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
